regfile_scoreboard: RTL and testbench

Parametrised RISC-V integer register file with an integrated scoreboard of pending writes, same-cycle write-to-read bypass, and a self-clearing init sequencer. It sits between decode/issue and writeback in the pipelined core. Decode reads operands and their busy status, issue marks the destination pending, and writeback commits data and clears the pending bit.

---
 rtl/regfile_scoreboard.sv | 215 +++++++++++++++++++++
 tb/tb_regfile_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// Integer register file with an integrated scoreboard of pending writes and a
// self-clearing init sequencer. Decode reads operands plus their busy status,
// issue marks a destination pending, writeback commits data and clears the
// pending bit.
//
// Optional feature (compile-time macro): REGFILE_BYPASS_EN
//   Defined   : a writeback in the current cycle is forwarded combinationally to
//               any read port addressing the same register (data = wb_data,
//               busy = 0).
//   Undefined : reads return the stored value and stored busy bit; writeback
//               effects become visible the following cycle.
//
// Parameters
//   DATA_WIDTH  register width in bits
//   ADDR_WIDTH  address width; DEPTH = 2**ADDR_WIDTH entries
//   ZERO_REG    when non-zero, register 0 reads as zero and is never busy
//
// Ports
//   clk                   clock, rising edge
//   rst                   reset, asynchronous, active-high
//   ready                 storage initialised, block accepting traffic
//   rd_addr1/2            read port addresses
//   rd_data1/2            read data (combinational)
//   rd_busy1/2            addressed register has a pending write
//   issue_valid/addr      request to mark a destination register pending
//   issue_stall           issue refused this cycle (WAW on a busy register)
//   wb_valid/addr/data    writeback strobe, register and data
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [ADDR_WIDTH-1:0] rd_addr2,
    output logic [DATA_WIDTH-1:0] rd_data1,
    output logic [DATA_WIDTH-1:0] rd_data2,
    output logic                  rd_busy1,
    output logic                  rd_busy2,
    input  logic                  issue_valid,
    input  logic [ADDR_WIDTH-1:0] issue_addr,
    output logic                  issue_stall,
    input  logic                  wb_valid,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   ptr_q, ptr_d;
    logic [DEPTH-1:0]        busy_q, busy_d;

    // Storage has no reset; the INIT sweep clears it.
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    logic                    run;
    logic                    wb_zero;
    logic                    issue_zero;
    logic                    wb_en;
    logic                    wb_hits_issue;
    logic                    issue_en;

    logic                    mem_we;
    logic [ADDR_WIDTH-1:0]   mem_waddr;
    logic [DATA_WIDTH-1:0]   mem_wdata;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign run   = (state_q == StRun);
    assign ready = run;

    assign wb_zero    = (ZERO_REG != 0) && (wb_addr == '0);
    assign issue_zero = (ZERO_REG != 0) && (issue_addr == '0);

    // A writeback only takes effect in RUN and never lands in a hardwired zero.
    assign wb_en = run & wb_valid & ~wb_zero;

    // A writeback retiring the current producer frees the register in the same
    // cycle, so a new issue to it may proceed. The comparison uses the raw
    // strobe; for a hardwired register 0 busy is never set, so it cannot stall.
    assign wb_hits_issue = wb_valid & (wb_addr == issue_addr);
    assign issue_stall   = run & issue_valid & busy_q[issue_addr] & ~wb_hits_issue;

    // Issues to a hardwired register 0 are accepted but record nothing.
    assign issue_en = run & issue_valid & ~issue_stall & ~issue_zero;

    // -------------------------------------------------------------------------
    // Init / run sequencer
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            StInit: begin
                ptr_d = ptr_q + ADDR_WIDTH'(1);
                if (ptr_q == LastAddr) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                // Terminal until the next reset.
                state_d = StRun;
            end
            default: begin
                state_d = StInit;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StInit;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // -------------------------------------------------------------------------
    // Storage write port: init sweep has priority (writeback is ignored then)
    // -------------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wb_addr;
        mem_wdata = wb_data;
        if (state_q == StInit) begin
            mem_we    = 1'b1;
            mem_waddr = ptr_q;
            mem_wdata = '0;
        end else if (wb_en) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    // -------------------------------------------------------------------------
    // Scoreboard: clear on writeback, then set on accepted issue so that a new
    // producer issued in the same cycle as the old one retires keeps the bit.
    // -------------------------------------------------------------------------
    always_comb begin
        busy_d = busy_q;
        if (wb_en) begin
            busy_d[wb_addr] = 1'b0;
        end
        if (issue_en) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // -------------------------------------------------------------------------
    // Read ports (combinational, independent)
    // -------------------------------------------------------------------------
    logic [ADDR_WIDTH-1:0] raddr [2];
    logic [DATA_WIDTH-1:0] rdata [2];
    logic                  rbusy [2];

    assign raddr[0] = rd_addr1;
    assign raddr[1] = rd_addr2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
            if (run && !((ZERO_REG != 0) && (raddr[p] == '0))) begin
`ifdef REGFILE_BYPASS_EN
                // wb_en already excludes writes dropped for register 0.
                if (wb_en && (wb_addr == raddr[p])) begin
                    rdata[p] = wb_data;
                    rbusy[p] = 1'b0;
                end else begin
                    rdata[p] = mem_q[raddr[p]];
                    rbusy[p] = busy_q[raddr[p]];
                end
`else
                rdata[p] = mem_q[raddr[p]];
                rbusy[p] = busy_q[raddr[p]];
`endif
            end
        end
    end

    assign rd_data1 = rdata[0];
    assign rd_data2 = rdata[1];
    assign rd_busy1 = rbusy[0];
    assign rd_busy2 = rbusy[1];

endmodule

// File: tb/tb_regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_regfile_scoreboard
//
// Self-checking bench for regfile_scoreboard (default parameters). Each cycle
// the bench derives expected outputs from a small reference model of the
// register file, queues them, and compares them against the DUT mid-cycle.
// Build with +define+REGFILE_BYPASS_EN to check the bypass variant.
// -----------------------------------------------------------------------------
module tb_regfile_scoreboard;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned DEPTH = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          ready;
    logic [AW-1:0] rd_addr1, rd_addr2;
    logic [DW-1:0] rd_data1, rd_data2;
    logic          rd_busy1, rd_busy2;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic          issue_stall;
    logic          wb_valid;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .ZERO_REG   (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ready       (ready),
        .rd_addr1    (rd_addr1),
        .rd_addr2    (rd_addr2),
        .rd_data1    (rd_data1),
        .rd_data2    (rd_data2),
        .rd_busy1    (rd_busy1),
        .rd_busy2    (rd_busy2),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .issue_stall (issue_stall),
        .wb_valid    (wb_valid),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data)
    );

    // ---------------------------------------------------------------------
    // Scoreboard queue and counters
    // ---------------------------------------------------------------------
    typedef enum int {SigReady, SigData1, SigBusy1, SigData2, SigBusy2, SigStall} sig_e;
    typedef struct {
        sig_e        sig;
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t  exp_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    string phase    = "start";

    // Reference model state
    logic [DW-1:0]    m_mem [DEPTH];
    logic [DEPTH-1:0] m_busy;
    logic             m_ready;
    int               m_ptr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] observe(input sig_e s);
        case (s)
            SigReady: return {31'b0, ready};
            SigData1: return rd_data1;
            SigBusy1: return {31'b0, rd_busy1};
            SigData2: return rd_data2;
            SigBusy2: return {31'b0, rd_busy2};
            default:  return {31'b0, issue_stall};
        endcase
    endfunction

    function automatic void push(input sig_e s, input string name, input logic [31:0] v);
        exp_t e;
        e.sig = s;
        e.tag = $sformatf("%s_%s", phase, name);
        e.val = v;
        exp_q.push_back(e);
    endfunction

    function automatic void model_read(input logic [AW-1:0] a, output logic [31:0] d,
                                       output logic b);
        d = '0;
        b = 1'b0;
        if (m_ready && a != 0) begin
`ifdef REGFILE_BYPASS_EN
            if (wb_valid && wb_addr == a) begin
                d = wb_data;
                b = 1'b0;
            end else begin
                d = m_mem[a];
                b = m_busy[a];
            end
`else
            d = m_mem[a];
            b = m_busy[a];
`endif
        end
    endfunction

    function automatic logic model_stall();
        return m_ready && issue_valid && issue_addr != 0 && m_busy[issue_addr]
               && !(wb_valid && wb_addr == issue_addr);
    endfunction

    task automatic push_expected();
        logic [31:0] d;
        logic        b;
        push(SigReady, "ready", {31'b0, m_ready});
        model_read(rd_addr1, d, b);
        push(SigData1, "rd_data1", d);
        push(SigBusy1, "rd_busy1", {31'b0, b});
        model_read(rd_addr2, d, b);
        push(SigData2, "rd_data2", d);
        push(SigBusy2, "rd_busy2", {31'b0, b});
        push(SigStall, "issue_stall", {31'b0, model_stall()});
    endtask

    task automatic compare_all();
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(e.tag, observe(e.sig), e.val);
        end
    endtask

    task automatic model_reset();
        m_ready = 1'b0;
        m_ptr   = 0;
        m_busy  = '0;
    endtask

    task automatic model_edge();
        logic st;
        if (rst) begin
            model_reset();
        end else if (!m_ready) begin
            m_mem[m_ptr] = '0;
            if (m_ptr == DEPTH - 1) m_ready = 1'b1;
            m_ptr++;
        end else begin
            st = model_stall();
            if (wb_valid && wb_addr != 0) begin
                m_mem[wb_addr]  = wb_data;
                m_busy[wb_addr] = 1'b0;
            end
            if (issue_valid && !st && issue_addr != 0) m_busy[issue_addr] = 1'b1;
        end
    endtask

    // Inputs are driven 1 time unit after a rising edge; outputs are sampled on
    // the falling edge; the model advances on the rising edge.
    task automatic cycle();
        push_expected();
        @(negedge clk);
        compare_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_addr  = '0;
        wb_valid    = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic wb(input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_valid = 1'b1;
        wb_addr  = a;
        wb_data  = d;
    endtask

    task automatic issue(input logic [AW-1:0] a);
        issue_valid = 1'b1;
        issue_addr  = a;
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (ready !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        check(tag, n, 32);
    endtask

    task automatic read_all_zero();
        idle();
        for (int a = 0; a < DEPTH; a += 2) begin
            rd_addr1 = AW'(a);
            rd_addr2 = AW'(a + 1);
            cycle();
        end
    endtask

    // ---------------------------------------------------------------------
    // Stimulus
    // ---------------------------------------------------------------------
    initial begin
        rst = 1'b1;
        idle();
        rd_addr1 = '0;
        rd_addr2 = '0;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        model_reset();

        phase = "reset";
        repeat (2) cycle();
        rst = 1'b0;

        // Traffic during INIT must be ignored.
        phase = "init";
        wb(3, 32'hFFFF_FFFF);
        issue(3);
        rd_addr1 = 3;
        rd_addr2 = 5;
        wait_ready("init_edges");

        phase = "init_done";
        read_all_zero();

        phase = "write";
        rd_addr1 = 5;
        rd_addr2 = 6;
        wb(5, 32'hDEAD_BEEF);
        cycle();
        idle();
        cycle();

        phase = "reg0";
        rd_addr1 = 0;
        rd_addr2 = 0;
        wb(0, 32'h0000_1234);
        issue(0);
        cycle();
        idle();
        issue(0);
        cycle();
        idle();
        cycle();

        phase = "sb";
        rd_addr1 = 7;
        rd_addr2 = 0;
        issue(7);
        cycle();
        issue(7);
        cycle();
        wb(7, 32'h0000_0055);
        issue(7);
        cycle();
        idle();
        cycle();
        wb(7, 32'h0000_0066);
        cycle();
        idle();
        cycle();

        phase = "dual";
        rd_addr1 = 4;
        rd_addr2 = 4;
        issue(4);
        cycle();
        wb(4, 32'hA5A5_A5A5);
        cycle();
        idle();
        cycle();

        // Dense traffic on a small register window to provoke collisions.
        phase = "random";
        for (int i = 0; i < 300; i++) begin
            wb_valid    = 1'($urandom_range(0, 1));
            wb_addr     = AW'($urandom_range(0, 7));
            wb_data     = $urandom;
            issue_valid = 1'($urandom_range(0, 1));
            issue_addr  = AW'($urandom_range(0, 7));
            rd_addr1    = AW'($urandom_range(0, 7));
            rd_addr2    = (i % 4 == 0) ? wb_addr : AW'($urandom_range(0, 31));
            cycle();
        end

        phase = "midrst";
        idle();
        rd_addr1 = 2;
        rd_addr2 = 9;
        issue(2);
        cycle();
        issue(9);
        cycle();
        idle();
        cycle();
        // Assert reset between edges; outputs must react without a clock.
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        push_expected();
        compare_all();
        cycle();
        rst = 1'b0;
        wait_ready("midrst_init_edges");
        phase = "midrst_done";
        read_all_zero();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached in phase %s", phase);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule
